// File: rtl/partial_histogram_gen_pkg.sv
// Shared HOG constants and the cell-output state type used by the histogram datapath.
package partial_histogram_gen_pkg;

    localparam int unsigned HOG_BINS       = 9;
    localparam int unsigned HOG_CELL_ROWS  = 8;
    localparam int unsigned HOG_CELL_COLS  = 8;
    localparam int unsigned HOG_BIN_WIDTH  = 11;
    localparam int unsigned HOG_ROW_STRIDE = HOG_BINS * HOG_BIN_WIDTH;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } hist_state_e;

endpackage

// File: rtl/row_bin_accumulator.sv
// One cell row's orientation bins: adds a magnitude into the selected bin, clearable.
module row_bin_accumulator #(
    parameter int unsigned BINS          = 9,
    parameter int unsigned BIN_WIDTH     = 11,
    parameter int unsigned BIN_IDX_WIDTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          add_en_i,
    input  logic                          clr_i,
    input  logic [BIN_IDX_WIDTH-1:0]      bin_idx_i,
    input  logic [BIN_WIDTH-1:0]          mag_i,
    output logic [BINS*BIN_WIDTH-1:0]     bins_next_o
);

    logic [BINS*BIN_WIDTH-1:0] bins_q;
    logic [BINS*BIN_WIDTH-1:0] bins_d;

    // bins_next_o includes the pending add so the cell output can capture the final pixel
    always_comb begin
        bins_next_o = bins_q;
        for (int unsigned b = 0; b < BINS; b++) begin
            if (add_en_i && (bin_idx_i == BIN_IDX_WIDTH'(b))) begin
                bins_next_o[b*BIN_WIDTH +: BIN_WIDTH] = bins_q[b*BIN_WIDTH +: BIN_WIDTH] + mag_i;
            end
        end
        bins_d = clr_i ? '0 : bins_next_o;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bins_q <= '0;
        end else begin
            bins_q <= bins_d;
        end
    end

endmodule

// File: rtl/partial_histogram_gen.sv
// Accumulates raster-ordered pixels into per-row bin histograms and hands each
// completed cell to a single-entry output register with valid/ready handshake.
module partial_histogram_gen
    import partial_histogram_gen_pkg::*;
#(
    parameter int unsigned MAG_WIDTH       = 8,
    parameter int unsigned BIN_IDX_WIDTH   = 4,
    parameter int unsigned INPUT_BIN_WIDTH = HOG_BIN_WIDTH,
    parameter int unsigned BINS            = HOG_BINS,
    parameter int unsigned CELL_COLS       = HOG_CELL_COLS,
    parameter int unsigned CELL_ROWS       = HOG_CELL_ROWS
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic                                        in_valid,
    output logic                                        in_ready,
    input  logic [MAG_WIDTH-1:0]                        in_mag,
    input  logic [BIN_IDX_WIDTH-1:0]                    in_bin,
    output logic                                        out_valid,
    input  logic                                        out_ready,
    output logic [INPUT_BIN_WIDTH*BINS*CELL_ROWS-1:0]   partial_histogram,
    output logic                                        bin_err
);

    localparam int unsigned ROW_W  = (BINS == HOG_BINS && INPUT_BIN_WIDTH == HOG_BIN_WIDTH)
                                     ? HOG_ROW_STRIDE : BINS * INPUT_BIN_WIDTH;
    localparam int unsigned HIST_W = ROW_W * CELL_ROWS;
    localparam int unsigned COL_CW = (CELL_COLS > 1) ? $clog2(CELL_COLS) : 1;
    localparam int unsigned ROW_CW = (CELL_ROWS > 1) ? $clog2(CELL_ROWS) : 1;
    localparam logic [COL_CW-1:0]        COL_LAST  = COL_CW'(CELL_COLS - 1);
    localparam logic [ROW_CW-1:0]        ROW_LAST  = ROW_CW'(CELL_ROWS - 1);
    localparam logic [BIN_IDX_WIDTH:0]   BIN_LIMIT = (BIN_IDX_WIDTH + 1)'(BINS);

    hist_state_e               state_q, state_d;
    logic [COL_CW-1:0]         col_q, col_d;
    logic [ROW_CW-1:0]         row_q, row_d;
    logic                      bin_err_q, bin_err_d;
    logic [HIST_W-1:0]         hist_q, hist_d;
    logic [HIST_W-1:0]         work_next;
    logic [INPUT_BIN_WIDTH-1:0] mag_ext;
    logic                      last_pix;
    logic                      accept;
    logic                      bin_ok;
    logic                      load;

    assign mag_ext  = INPUT_BIN_WIDTH'(in_mag);
    assign last_pix = (col_q == COL_LAST) && (row_q == ROW_LAST);
    assign bin_ok   = ({1'b0, in_bin} < BIN_LIMIT);
    assign accept   = rst_n && in_valid && in_ready;
    assign load     = accept && last_pix;

    for (genvar r = 0; r < CELL_ROWS; r++) begin : g_row
        row_bin_accumulator #(
            .BINS          (BINS),
            .BIN_WIDTH     (INPUT_BIN_WIDTH),
            .BIN_IDX_WIDTH (BIN_IDX_WIDTH)
        ) u_row_acc (
            .clk         (clk),
            .rst_n       (rst_n),
            .add_en_i    (accept && bin_ok && (row_q == ROW_CW'(r))),
            .clr_i       (load),
            .bin_idx_i   (in_bin),
            .mag_i       (mag_ext),
            .bins_next_o (work_next[r*ROW_W +: ROW_W])
        );
    end

    // The closing pixel is only blocked when the held cell cannot leave this cycle
    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        row_d     = row_q;
        bin_err_d = bin_err_q;
        hist_d    = hist_q;
        out_valid = (state_q == ST_FULL);
        in_ready  = 1'b1;

        if (rst_n && (state_q == ST_FULL) && !out_ready && last_pix) begin
            in_ready = 1'b0;
        end

        if (accept) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
            if (!bin_ok) begin
                bin_err_d = 1'b1;
            end
        end

        if (load) begin
            hist_d  = work_next;
            state_d = ST_FULL;
        end else if ((state_q == ST_FULL) && out_ready) begin
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_EMPTY;
            col_q     <= '0;
            row_q     <= '0;
            bin_err_q <= 1'b0;
            hist_q    <= '0;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            row_q     <= row_d;
            bin_err_q <= bin_err_d;
            hist_q    <= hist_d;
        end
    end

    assign partial_histogram = hist_q;
    assign bin_err           = bin_err_q;

endmodule

// File: tb/tb_partial_histogram_gen.sv
// Directed and randomized checks of partial_histogram_gen against a pixel-counting reference model.
module tb_partial_histogram_gen;

    localparam int unsigned NB   = 9;
    localparam int unsigned NR   = 8;
    localparam int unsigned NC   = 8;
    localparam int unsigned W    = 11;
    localparam int unsigned MW   = 8;
    localparam int unsigned IW   = 4;
    localparam int unsigned HW   = W * NB * NR;
    localparam int unsigned RS   = W * NB;
    localparam int unsigned PIX  = NR * NC;
    localparam int unsigned RAND_CELLS = 100;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [MW-1:0] in_mag = '0;
    logic [IW-1:0] in_bin = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [HW-1:0] partial_histogram;
    logic          bin_err;

    always #5 clk = ~clk;

    partial_histogram_gen #(
        .MAG_WIDTH       (MW),
        .BIN_IDX_WIDTH   (IW),
        .INPUT_BIN_WIDTH (W),
        .BINS            (NB),
        .CELL_COLS       (NC),
        .CELL_ROWS       (NR)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_mag            (in_mag),
        .in_bin            (in_bin),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .partial_histogram (partial_histogram),
        .bin_err           (bin_err)
    );

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic check(input string tag, input logic [HW-1:0] got, input logic [HW-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference model: pixels are counted per cell, row = count / columns
    int unsigned   acc [NR][NB];
    int unsigned   pix_cnt    = 0;
    bit            err_m      = 1'b0;
    logic [HW-1:0] cells_q [$];
    int unsigned   acc_total  = 0;
    int unsigned   sent_total = 0;
    int unsigned   cells_out  = 0;
    bit            exp_ready_m;

    function automatic void model_clear();
        for (int r = 0; r < NR; r++)
            for (int b = 0; b < NB; b++) acc[r][b] = 0;
        pix_cnt = 0;
        err_m   = 1'b0;
        cells_q.delete();
    endfunction

    function automatic void model_pixel(input int unsigned mag, input int unsigned bin);
        logic [HW-1:0] v;
        int unsigned row;
        row = pix_cnt / NC;
        if (bin < NB) acc[row][bin] += mag;
        else err_m = 1'b1;
        pix_cnt++;
        acc_total++;
        if (pix_cnt == PIX) begin
            v = '0;
            for (int r = 0; r < NR; r++)
                for (int b = 0; b < NB; b++) begin
                    v[(r*NB + b)*W +: W] = W'(acc[r][b]);
                    acc[r][b] = 0;
                end
            cells_q.push_back(v);
            pix_cnt = 0;
        end
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_in_ready", in_ready, 1'b1);
            model_clear();
        end else begin
            exp_ready_m = !((cells_q.size() != 0) && !out_ready && (pix_cnt == PIX - 1));
            check("in_ready", in_ready, exp_ready_m);
            check("out_valid", out_valid, cells_q.size() != 0);
            check("bin_err", bin_err, err_m);
            if (cells_q.size() != 0) check("hist", partial_histogram, cells_q[0]);
            check("queue_depth", cells_q.size() <= 1, 1'b1);
            if (out_valid && out_ready && cells_q.size() != 0) begin
                void'(cells_q.pop_front());
                cells_out++;
            end
            if (in_valid && in_ready) model_pixel(in_mag, in_bin);
        end
    end

    bit rnd_ready = 1'b0;

    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send_pixel(input int unsigned mag, input int unsigned bin);
        int unsigned waited;
        bit done;
        waited = 0;
        done   = 1'b0;
        in_valid = 1'b1;
        in_mag   = MW'(mag);
        in_bin   = IW'(bin);
        while (!done) begin
            @(negedge clk);
            done = in_ready;
            tick();
            waited++;
            if (!done && waited > 2000) begin
                check("send_timeout", done, 1'b1);
                break;
            end
        end
        in_valid = 1'b0;
        if (done) sent_total++;
    endtask

    task automatic drain();
        int unsigned n;
        n = 0;
        rnd_ready = 1'b0;
        out_ready = 1'b1;
        while (out_valid && n < 50) begin
            tick();
            n++;
        end
        check("drain", out_valid, 1'b0);
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rst_n    = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_bin_err", bin_err, 1'b0);
        check("rst_hist", partial_histogram, '0);
    endtask

    function automatic int unsigned rand_bin();
        return ($urandom_range(0, 40) == 0) ? $urandom_range(NB, 15) : $urandom_range(0, NB - 1);
    endfunction

    logic [HW-1:0] snap_a;

    initial begin
        tick();
        do_reset();

        // all ones into bin 0: result visible one cycle after the last handshake
        out_ready = 1'b0;
        for (int i = 0; i < PIX; i++) send_pixel(1, 0);
        check("c1_latency", out_valid, 1'b1);
        for (int r = 0; r < NR; r++) begin
            check("c1_bin0", partial_histogram[r*RS +: W], 8);
            check("c1_bin1", partial_histogram[r*RS + W +: W], 0);
        end
        drain();

        // maximum magnitude into the top bin must not wrap
        for (int i = 0; i < PIX; i++) send_pixel(255, 8);
        for (int r = 0; r < NR; r++) check("c2_bin8", partial_histogram[r*RS + 8*W +: W], 2040);
        drain();

        // second cell streams in while the first is held
        out_ready = 1'b0;
        for (int i = 0; i < PIX; i++) send_pixel($urandom_range(0, 255), $urandom_range(0, NB - 1));
        snap_a = partial_histogram;
        for (int i = 0; i < PIX - 1; i++) send_pixel($urandom_range(0, 255), $urandom_range(0, NB - 1));
        check("a_stable", partial_histogram, snap_a);
        in_valid = 1'b1;
        in_mag   = MW'($urandom_range(0, 255));
        in_bin   = IW'($urandom_range(0, NB - 1));
        @(negedge clk);
        check("b64_blocked", in_ready, 1'b0);
        tick();
        out_ready = 1'b1;
        @(negedge clk);
        check("b64_ready", in_ready, 1'b1);
        check("b64_valid", out_valid, 1'b1);
        tick();
        in_valid = 1'b0;
        sent_total++;
        check("b_follow", out_valid, 1'b1);
        check("b_not_a", partial_histogram != snap_a, 1'b1);
        drain();

        // illegal bin on pixel 5 flags an error and contributes nothing
        for (int i = 0; i < PIX; i++) begin
            if (i == 4) send_pixel(100, 12);
            else send_pixel(3, 1);
        end
        check("err_set", bin_err, 1'b1);
        check("err_row0_bin1", partial_histogram[1*W +: W], 21);
        check("err_row1_bin1", partial_histogram[RS + W +: W], 24);
        drain();
        check("err_sticky", bin_err, 1'b1);

        // reset mid-cell discards the partial accumulation
        for (int i = 0; i < 30; i++) send_pixel($urandom_range(1, 255), $urandom_range(0, NB - 1));
        do_reset();
        for (int i = 0; i < PIX; i++) send_pixel(2, 3);
        for (int r = 0; r < NR; r++) check("rst_bin3", partial_histogram[r*RS + 3*W +: W], 16);
        drain();

        // randomized flow with gaps on both sides
        rnd_ready = 1'b1;
        for (int c = 0; c < RAND_CELLS; c++) begin
            for (int i = 0; i < PIX; i++) begin
                if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) tick();
                send_pixel($urandom_range(0, 255), rand_bin());
            end
        end
        drain();

        check("cells_out", cells_out, 6 + RAND_CELLS);
        check("pixels", acc_total, sent_total);
        check("leftover", cells_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/partial_histogram_gen.md
PARTIAL_HISTOGRAM_GEN -- requirements
Module: partial_histogram_gen

Interface
REQ-001 SHALL have parameter MAG_WIDTH, default 8, meaning the pixel gradient-magnitude width.
REQ-002 SHALL have parameter BIN_IDX_WIDTH, default 4, meaning the orientation bin-index width.
REQ-003 SHALL have parameter INPUT_BIN_WIDTH, default 11, meaning the per-row bin accumulator width.
REQ-004 SHALL have parameter BINS, default 9, meaning the number of histogram bins.
REQ-005 SHALL have parameters CELL_COLS, default 8, and CELL_ROWS, default 8, meaning the pixels per cell row and the rows per cell.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-007 SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-008 SHALL have port in_valid, input, 1 bit: pixel valid.
REQ-009 SHALL have port in_ready, output, 1 bit: pixel accepted when in_valid && in_ready.
REQ-010 SHALL have port in_mag, input, MAG_WIDTH: pixel magnitude.
REQ-011 SHALL have port in_bin, input, BIN_IDX_WIDTH: pixel bin index, legal range 0..BINS-1.
REQ-012 SHALL have port out_valid, output, 1 bit: partial_histogram holds a complete cell.
REQ-013 SHALL have port out_ready, input, 1 bit: cell consumed when out_valid && out_ready.
REQ-014 SHALL have port partial_histogram, output, INPUT_BIN_WIDTH*BINS*CELL_ROWS (792) bits: 8 row histograms.
REQ-015 SHALL have port bin_err, output, 1 bit: sticky flag set when an out-of-range in_bin is accepted.

Function
REQ-016 SHALL accept pixels in cell raster order, CELL_COLS pixels of row 0, then row 1, through row CELL_ROWS-1 (64 pixels per cell).
REQ-017 SHALL keep a column counter (0..7) and a row counter (0..7), advancing the column on each accepted pixel, wrapping to 0 at 7, and advancing the row on column wrap; the row counter wraps to 0 after the 64th pixel.
REQ-018 SHALL add each accepted in_mag, zero-extended, into working bin [row][in_bin], where bin b of row r occupies bits r*99 + b*11 +: 11.
REQ-019 SHALL NOT saturate or handle overflow (max 8*255 = 2040 < 2^11).
REQ-020 SHALL, when in_bin >= BINS, count the pixel, update no bin, and set bin_err.
REQ-021 SHALL implement a 2-state FSM: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-022 SHALL, on acceptance of the 64th pixel, load the output register with the working histogram including that pixel, clear all working bins, and enter FULL in the next cycle; latency is 1 cycle from the last-pixel handshake to out_valid.
REQ-023 SHALL go FULL->EMPTY on out_valid && out_ready unless a 64th pixel is accepted in the same cycle, in which case it stays FULL with the new cell loaded.
REQ-024 SHALL drive in_ready = 1, except 0 when state is FULL && !out_ready && the pending pixel is the 64th (col=7, row=7); pixels 1..63 of the next cell are accepted while FULL.
REQ-025 SHALL hold partial_histogram stable while out_valid && !out_ready.
REQ-026 SHALL leave in_ready independent of in_valid, and out_valid independent of out_ready, with no combinational in_valid->out_valid path.

Reset
REQ-027 SHALL, on rst_n=0 at a clock edge, clear counters, working bins, output register and bin_err, set the state to EMPTY, and drive out_valid=0.
REQ-028 SHALL discard any partially accumulated cell on reset mid-operation; the first pixel after release is row 0 col 0.
REQ-029 SHALL, during reset, drive in_ready=1, with handshakes in that cycle ignored.

Structure
REQ-030 SHALL take BINS, CELL_ROWS, CELL_COLS, INPUT_BIN_WIDTH and the row stride (99) from the shared HOG package, together with the state enum.
REQ-031 SHALL use one sub-module, row_bin_accumulator (one row's 9 bins with add/clear), instantiated CELL_ROWS times with a row-enable.

Verification
REQ-032 SHALL cover: 64 pixels all mag=1, bin=0 -> one cycle later out_valid=1, each row bin0=8, all other bins 0.
REQ-033 SHALL cover: 64 pixels mag=255, bin=8 -> every row bin8=2040, no wrap.
REQ-034 SHALL cover: out_ready=0 held, a second cell of 63 pixels sent -> all 63 accepted, in_ready=0 on the 64th, first cell stable; out_ready=1 -> both handshakes fire in the same cycle, out_valid stays 1 and the second cell appears next cycle.
REQ-035 SHALL cover: pixel 5 with bin=12 -> bin_err=1 and stays set, cell completes after 64 pixels with that magnitude absent.
REQ-036 SHALL cover: rst_n low after 30 pixels, then 64 pixels mag=2, bin=3 -> each row bin3=16, no residue from the first 30.
REQ-037 SHALL cover: random in_valid/out_ready gaps over 100 cells -> output matches the reference model and no pixel is lost or duplicated.
